// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with built-in test patterns.
// One pixel per CLK. It produces h_sync, v_sync, on_screen, frame_start and
// line_start, plus registered RGB from black, colour bars, a checkerboard or an
// external pixel source. Every output lags req_x/req_y by one clock.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output and
// makes the checkerboard scroll horizontally by frame_count pixels.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int COLOR_BITS = 1,
   parameter int CHECK_LOG2 = 3,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW        = $clog2(H_TOTAL),
   localparam int VW        = $clog2(V_TOTAL)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [1:0]            pattern_sel,
   output logic [HW-1:0]         req_x,
   output logic [VW-1:0]         req_y,
   input  logic [COLOR_BITS-1:0] ext_r,
   input  logic [COLOR_BITS-1:0] ext_g,
   input  logic [COLOR_BITS-1:0] ext_b,
   output logic [COLOR_BITS-1:0] red,
   output logic [COLOR_BITS-1:0] green,
   output logic [COLOR_BITS-1:0] blue,
   output logic                  h_sync,
   output logic                  v_sync,
   output logic                  on_screen,
   output logic                  frame_start,
   output logic                  line_start
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [15:0]           frame_count
`endif
);

   typedef enum logic [1:0] {
      PAT_BLACK = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_EXT   = 2'd3
   } pat_e;

   // Region bounds are one bit wider than the counters so that a bound equal
   // to the total (e.g. zero back porch) still fits.
   localparam logic [HW:0]   H_ACT_L  = (HW+1)'(H_ACTIVE);
   localparam logic [HW:0]   HS_BEG   = (HW+1)'(H_ACTIVE + H_FP);
   localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW:0]   V_ACT_L  = (VW+1)'(V_ACTIVE);
   localparam logic [VW:0]   VS_BEG   = (VW+1)'(V_ACTIVE + V_FP);
   localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

   // Colour bars: eight bars of BAR_W pixels, tracked by a pixel-in-bar counter.
   localparam int            BAR_W    = H_ACTIVE / 8;
   localparam int            BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   // Checker bit is picked with a mask wide enough for either counter and for
   // CHECK_LOG2, so an out-of-range square size simply reads zero.
   localparam int            CW_HV    = (HW > VW) ? HW : VW;
   localparam int            CW       = (CW_HV > CHECK_LOG2) ? CW_HV : CHECK_LOG2 + 1;
   localparam logic [CW-1:0] CHK_MASK = CW'(1) << CHECK_LOG2;

   logic [HW-1:0]         h_cnt;
   logic [VW-1:0]         v_cnt;
   logic                  h_wrap;
   logic                  v_wrap;
   logic                  frame_origin;
   logic                  h_active;
   logic                  active;
   logic                  h_in_sync;
   logic                  v_in_sync;
   logic [BW-1:0]         bar_px;
   logic [2:0]            bar_idx;
   pat_e                  mode;
   pat_e                  mode_eff;
   logic [HW-1:0]         chk_h;
   logic                  checker_on;
   logic [COLOR_BITS-1:0] pix_r;
   logic [COLOR_BITS-1:0] pix_g;
   logic [COLOR_BITS-1:0] pix_b;

   assign h_wrap       = (h_cnt == H_LAST);
   assign v_wrap       = (v_cnt == V_LAST);
   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
   assign h_active     = ({1'b0, h_cnt} < H_ACT_L);
   assign active       = h_active && ({1'b0, v_cnt} < V_ACT_L);
   assign h_in_sync    = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
   assign v_in_sync    = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);

   assign req_x = h_cnt;
   assign req_y = v_cnt;

   // Raster position: h_cnt every clock, v_cnt on each line wrap.
   always_ff @(posedge CLK) begin
      if (RST) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Bar index follows h_cnt through the active part of the line, restarting
   // each line, so no divider is needed.
   always_ff @(posedge CLK) begin
      if (RST || h_wrap) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (h_active) begin
         if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 1'b1;
         end else begin
            bar_px <= bar_px + 1'b1;
         end
      end
   end

   // Pattern is latched at the frame origin; that first pixel already uses the
   // new selection so the whole frame is drawn in one mode.
   assign mode_eff = frame_origin ? pat_e'(pattern_sel) : mode;

   // Pattern mode register, updated only at the frame origin.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode <= PAT_BLACK;
      end else if (frame_origin) begin
         mode <= pat_e'(pattern_sel);
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] fc_eff;

   // The count bumps together with frame_start; the pixel at the origin uses
   // the bumped value so the scroll offset is constant across the frame.
   assign fc_eff = frame_origin ? frame_count + 16'd1 : frame_count;
   assign chk_h  = h_cnt + HW'(fc_eff);

   // Frame counter, advanced at every frame origin.
   always_ff @(posedge CLK) begin
      if (RST) begin
         frame_count <= '0;
      end else if (frame_origin) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`else
   assign chk_h = h_cnt;
`endif

   assign checker_on = |((CW'(chk_h) ^ CW'(v_cnt)) & CHK_MASK);

   // Pixel colour for the current counter position, before blanking.
   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      case (mode_eff)
         PAT_BARS: begin
            pix_r = {COLOR_BITS{~bar_idx[2]}};
            pix_g = {COLOR_BITS{~bar_idx[1]}};
            pix_b = {COLOR_BITS{~bar_idx[0]}};
         end
         PAT_CHECK: begin
            pix_r = {COLOR_BITS{checker_on}};
            pix_g = {COLOR_BITS{checker_on}};
            pix_b = {COLOR_BITS{checker_on}};
         end
         PAT_EXT: begin
            pix_r = ext_r;
            pix_g = ext_g;
            pix_b = ext_b;
         end
         default: ;
      endcase
   end

   // Registered video outputs; colour is blanked outside the active region.
   always_ff @(posedge CLK) begin
      if (RST) begin
         on_screen   <= 1'b0;
         h_sync      <= ~H_SYNC_POL;
         v_sync      <= ~V_SYNC_POL;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
      end else begin
         on_screen   <= active;
         h_sync      <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
         v_sync      <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
         frame_start <= frame_origin;
         line_start  <= (h_cnt == '0) && ({1'b0, v_cnt} < V_ACT_L);
         red         <= active ? pix_r : '0;
         green       <= active ? pix_g : '0;
         blue        <= active ? pix_b : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench for vga_timing_gen.
// Two instances share stimulus: active-low and active-high sync polarity.
// The reference model tracks the raster position as plain integers and
// derives every pixel from the timing/pattern rules with arithmetic.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
   localparam int CB = 2,  CL = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);
   localparam int PW = 5 + 3*CB;
   localparam int RQW = 2*(HW + VW);
`ifdef VGA_FRAME_COUNT_EN
   localparam int VECW = 2*PW + 32;
   localparam bit FC_EN = 1'b1;
`else
   localparam int VECW = 2*PW;
   localparam bit FC_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [1:0]    pattern_sel = 2'd0;
   logic [CB-1:0] ext_r = '0, ext_g = '0, ext_b = '0;
   logic [HW-1:0] req_x, req_x_p;
   logic [VW-1:0] req_y, req_y_p;
   logic [CB-1:0] red, green, blue, red_p, green_p, blue_p;
   logic          h_sync, v_sync, on_screen, frame_start, line_start;
   logic          h_sync_p, v_sync_p, on_screen_p, frame_start_p, line_start_p;
`ifdef VGA_FRAME_COUNT_EN
   logic [15:0]   frame_count, frame_count_p;
`endif

   int checks = 0;
   int errors = 0;

   // model state: raster position, frame mode, frame count
   int m_x = 0, m_y = 0, m_mode = 0, m_fc = 0;
   int px = -1, py = -1;
   logic [CB-1:0]   last_er, last_eg, last_eb;
   logic [VECW-1:0] exp_vec;
   logic [RQW-1:0]  exp_req, obs_req;

   always #5 CLK = ~CLK;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
      .COLOR_BITS(CB), .CHECK_LOG2(CL)
   ) dut (
      .CLK(CLK), .RST(RST), .pattern_sel(pattern_sel),
      .req_x(req_x), .req_y(req_y),
      .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
      .red(red), .green(green), .blue(blue),
      .h_sync(h_sync), .v_sync(v_sync), .on_screen(on_screen),
      .frame_start(frame_start), .line_start(line_start)
`ifdef VGA_FRAME_COUNT_EN
      , .frame_count(frame_count)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
      .COLOR_BITS(CB), .CHECK_LOG2(CL)
   ) dut_p (
      .CLK(CLK), .RST(RST), .pattern_sel(pattern_sel),
      .req_x(req_x_p), .req_y(req_y_p),
      .ext_r(ext_r), .ext_g(ext_g), .ext_b(ext_b),
      .red(red_p), .green(green_p), .blue(blue_p),
      .h_sync(h_sync_p), .v_sync(v_sync_p), .on_screen(on_screen_p),
      .frame_start(frame_start_p), .line_start(line_start_p)
`ifdef VGA_FRAME_COUNT_EN
      , .frame_count(frame_count_p)
`endif
   );

   // expected {on,hs,vs,fs,ls,r,g,b} for pixel (x,y)
   function automatic logic [PW-1:0] model_pix(input int x, input int y, input int md,
                                               input int fc, input logic [CB-1:0] er,
                                               input logic [CB-1:0] eg, input logic [CB-1:0] eb,
                                               input bit pol);
      logic on, hs, vs, fs, ls;
      logic [CB-1:0] r, g, b;
      int bar;
      bit white;
      on = (x < HA) && (y < VA);
      hs = ((x >= HA+HF) && (x < HA+HF+HS)) ? pol : !pol;
      vs = ((y >= VA+VF) && (y < VA+VF+VS)) ? pol : !pol;
      fs = (x == 0) && (y == 0);
      ls = (x == 0) && (y < VA);
      r = '0; g = '0; b = '0;
      if (on) begin
         case (md)
            1: begin
               bar = x / (HA/8);
               r = ((bar & 4) != 0) ? '0 : '1;
               g = ((bar & 2) != 0) ? '0 : '1;
               b = ((bar & 1) != 0) ? '0 : '1;
            end
            2: begin
               white = ((((((x + fc) % (1 << HW)) >> CL) ^ (y >> CL)) & 1) == 1);
               r = white ? '1 : '0;
               g = r;
               b = r;
            end
            3: begin
               r = er; g = eg; b = eb;
            end
            default: ;
         endcase
      end
      return {on, hs, vs, fs, ls, r, g, b};
   endfunction

   function automatic logic [VECW-1:0] obs_vec();
      return {on_screen, h_sync, v_sync, frame_start, line_start, red, green, blue,
              on_screen_p, h_sync_p, v_sync_p, frame_start_p, line_start_p, red_p, green_p, blue_p
`ifdef VGA_FRAME_COUNT_EN
              , frame_count, frame_count_p
`endif
             };
   endfunction

   // one pixel clock: drive at negedge, predict, advance, return at next negedge
   task automatic tick(input bit r, input logic [1:0] ps);
      logic [CB-1:0] er, eg, eb;
      logic [PW-1:0] e0, e1;
      er = CB'($urandom); eg = CB'($urandom); eb = CB'($urandom);
      RST = r; pattern_sel = ps; ext_r = er; ext_g = eg; ext_b = eb;
      last_er = er; last_eg = eg; last_eb = eb;
      #1;
      obs_req = {req_x, req_y, req_x_p, req_y_p};
      exp_req = {HW'(m_x), VW'(m_y), HW'(m_x), VW'(m_y)};
      if (r) begin
         e0 = {1'b0, 1'b1, 1'b1, 2'b00, {3*CB{1'b0}}};
         e1 = {1'b0, 1'b0, 1'b0, 2'b00, {3*CB{1'b0}}};
         m_x = 0; m_y = 0; m_mode = 0; m_fc = 0;
         px = -1; py = -1;
      end else begin
         if (m_x == 0 && m_y == 0) begin
            m_mode = int'(ps);
            m_fc = (m_fc + 1) % 65536;
         end
         e0 = model_pix(m_x, m_y, m_mode, FC_EN ? m_fc : 0, er, eg, eb, 1'b0);
         e1 = model_pix(m_x, m_y, m_mode, FC_EN ? m_fc : 0, er, eg, eb, 1'b1);
         px = m_x; py = m_y;
         m_x++;
         if (m_x == HT) begin
            m_x = 0;
            m_y = (m_y + 1) % VT;
         end
      end
`ifdef VGA_FRAME_COUNT_EN
      exp_vec = {e0, e1, 16'(m_fc), 16'(m_fc)};
`else
      exp_vec = {e0, e1};
`endif
      @(negedge CLK);
   endtask

   task automatic run_to_origin(input logic [1:0] ps);
      for (int i = 0; i < HT*VT && !(m_x == 0 && m_y == 0); i++) tick(1'b0, ps);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 2'($urandom));
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL reset_out: got %h expected %h", obs_vec(), exp_vec);
         end
         checks++;
         if (obs_req !== exp_req) begin
            errors++; $display("FAIL reset_req: got %h expected %h", obs_req, exp_req);
         end
      end
      checks++;
      if ({h_sync, v_sync, h_sync_p, v_sync_p} !== 4'b1100) begin
         errors++; $display("FAIL reset_idle_sync: got %b expected 1100",
                            {h_sync, v_sync, h_sync_p, v_sync_p});
      end
      tick(1'b0, 2'd0);
      checks++;
      if (frame_start !== 1'b1) begin
         errors++; $display("FAIL first_frame_start: got %b expected 1", frame_start);
      end
   endtask

   task automatic test_timing();
      int since, low_cnt, first_off, vs_low, last_fs;
      since = -100000; low_cnt = 0; first_off = -1; vs_low = 0; last_fs = -1;
      for (int cyc = 0; cyc < 3*HT*VT; cyc++) begin
         tick(1'b0, 2'd0);
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL timing_out: got %h expected %h", obs_vec(), exp_vec);
         end
         checks++;
         if (obs_req !== exp_req) begin
            errors++; $display("FAIL timing_req: got %h expected %h", obs_req, exp_req);
         end
         if (line_start === 1'b1) begin
            since = 0; low_cnt = 0; first_off = -1;
         end else begin
            since++;
         end
         if (h_sync === 1'b0) begin
            if (low_cnt == 0) first_off = since;
            low_cnt++;
         end
         if (since == HT-1) begin
            checks++;
            if (low_cnt !== HS) begin
               errors++; $display("FAIL hsync_width: got %0d expected %0d", low_cnt, HS);
            end
            checks++;
            if (first_off !== HA+HF) begin
               errors++; $display("FAIL hsync_offset: got %0d expected %0d", first_off, HA+HF);
            end
         end
         if (v_sync === 1'b0) vs_low++;
         if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (cyc - last_fs !== HT*VT) begin
                  errors++; $display("FAIL frame_period: got %0d expected %0d", cyc - last_fs, HT*VT);
               end
               checks++;
               if (vs_low !== VS*HT) begin
                  errors++; $display("FAIL vsync_width: got %0d expected %0d", vs_low, VS*HT);
               end
            end
            last_fs = cyc;
            vs_low = 0;
         end
      end
   endtask

   task automatic test_bars();
      run_to_origin(2'd1);
      for (int i = 0; i < HT*VT; i++) begin
         tick(1'b0, 2'd1);
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL bars_out: got %h expected %h", obs_vec(), exp_vec);
         end
         if (py < VA && (px == 0 || px == 1)) begin
            checks++;
            if ({red, green, blue} !== 6'b11_11_11) begin
               errors++; $display("FAIL bars_white: x=%0d got %b expected 111111", px, {red, green, blue});
            end
         end
         if (py < VA && px == 4) begin
            checks++;
            if ({red, green, blue} !== 6'b11_00_11) begin
               errors++; $display("FAIL bars_bar2: got %b expected 110011", {red, green, blue});
            end
         end
         if (py < VA && (px == 14 || px == 15)) begin
            checks++;
            if ({red, green, blue} !== 6'b00_00_00) begin
               errors++; $display("FAIL bars_black: x=%0d got %b expected 000000", px, {red, green, blue});
            end
         end
         if (px >= HA || py >= VA) begin
            checks++;
            if ({red, green, blue, on_screen} !== 7'b0) begin
               errors++; $display("FAIL bars_blank: got %b expected 0000000", {red, green, blue, on_screen});
            end
         end
      end
   endtask

   task automatic test_checker();
      run_to_origin(2'd2);
      for (int i = 0; i < 2*HT*VT; i++) begin
         tick(1'b0, 2'd2);
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL checker_out: got %h expected %h", obs_vec(), exp_vec);
         end
      end
   endtask

   task automatic test_ext();
      run_to_origin(2'd3);
      for (int i = 0; i < HT*VT; i++) begin
         tick(1'b0, (i < 60) ? 2'd3 : 2'd1);
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL ext_out: got %h expected %h", obs_vec(), exp_vec);
         end
         if (px < HA && py < VA) begin
            checks++;
            if ({red, green, blue} !== {last_er, last_eg, last_eb}) begin
               errors++; $display("FAIL ext_hold: got %b expected %b", {red, green, blue},
                                  {last_er, last_eg, last_eb});
            end
         end
      end
      tick(1'b0, 2'd1);
      checks++;
      if ({frame_start, red, green, blue} !== 7'b1_11_11_11) begin
         errors++; $display("FAIL ext_switch: got %b expected 1111111", {frame_start, red, green, blue});
      end
   endtask

   task automatic test_mid_reset();
      int n;
      n = 0;
      while (!(m_x == 10 && m_y == 2) && n < 2*HT*VT) begin
         tick(1'b0, 2'($urandom));
         n++;
      end
      if (n >= 2*HT*VT) begin
         checks++; errors++;
         $display("FAIL mid_reset_reach: got %0d cycles expected under %0d", n, 2*HT*VT);
      end
      tick(1'b1, 2'd2);
      checks++;
      if (obs_vec() !== exp_vec) begin
         errors++; $display("FAIL mid_reset_out: got %h expected %h", obs_vec(), exp_vec);
      end
      checks++;
      if ({req_x, req_y} !== '0) begin
         errors++; $display("FAIL mid_reset_req: got %h expected 0", {req_x, req_y});
      end
      tick(1'b0, 2'd2);
      checks++;
      if (frame_start !== 1'b1) begin
         errors++; $display("FAIL mid_reset_fs: got %b expected 1", frame_start);
      end
   endtask

   task automatic test_random();
      logic [1:0] ps;
      ps = 2'd0;
      for (int i = 0; i < 5*HT*VT; i++) begin
         if ($urandom_range(0, 39) == 0) ps = 2'($urandom);
         tick($urandom_range(0, 299) == 0, ps);
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL random_out: got %h expected %h", obs_vec(), exp_vec);
         end
         checks++;
         if (obs_req !== exp_req) begin
            errors++; $display("FAIL random_req: got %h expected %h", obs_req, exp_req);
         end
      end
   endtask

`ifdef VGA_FRAME_COUNT_EN
   task automatic test_frame_count();
      tick(1'b1, 2'd2);
      for (int i = 0; i < 2*HT*VT + 1; i++) begin
         tick(1'b0, 2'd2);
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++; $display("FAIL frame_count_out: got %h expected %h", obs_vec(), exp_vec);
         end
      end
      checks++;
      if (frame_count !== 16'd3) begin
         errors++; $display("FAIL frame_count_value: got %0d expected 3", frame_count);
      end
   endtask
`endif

   initial begin
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      test_reset();
      test_timing();
      test_bars();
      test_checker();
      test_ext();
      test_mid_reset();
      test_random();
`ifdef VGA_FRAME_COUNT_EN
      test_frame_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
